// File: rtl/s3g_reply_seq.sv
// ---------------------------------------------------------------------------
// s3g_reply_seq
//
// Reply sequencer for the S3G host link. Starts the command executor for
// each good packet (or skips it on a CRC error), waits for completion or
// timeout, then frames the reply
//     0xD5, 1+len, status, payload[0..len-1], crc8
// and streams it one byte at a time out of the UART the command came in on.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_rx_packet_done/error packet receiver pulses, i_rx_cmd_src = port (0/1)
//   o_cmd_start            one-cycle executor start pulse
//   i_exec_done/status/len executor completion, status and payload length
//   o_reply_addr/i_reply_data  executor reply byte read port (combinational)
//   o_txN_data/o_txN_start/i_txN_busy  byte-wide UART transmitters 1 and 2
//   o_busy                 a reply is in progress
//   o_dropped              packet event ignored because busy
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a packet event
// EXEC    | executor running, timeout counter advancing
// HDR     | sync byte 0xD5
// LEN     | length byte (1 + payload length)
// STAT    | status byte
// DATA    | payload bytes, reply_addr = byte index
// CRC     | CRC-8 over status and payload
// Each send state has a SEND phase (r_wait = 0, start strobe high) and a
// WAIT phase (r_wait = 1) that polls the selected UART's busy.
// ---------------------------------------------------------------------------
module s3g_reply_seq #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_packet_done,
    input  logic       i_rx_packet_error,
    input  logic       i_rx_cmd_src,
    output logic       o_cmd_start,
    input  logic       i_exec_done,
    input  logic [7:0] i_exec_status,
    input  logic [4:0] i_exec_len,
    output logic [3:0] o_reply_addr,
    input  logic [7:0] i_reply_data,
    output logic [7:0] o_tx1_data,
    output logic       o_tx1_start,
    input  logic       i_tx1_busy,
    output logic [7:0] o_tx2_data,
    output logic       o_tx2_start,
    input  logic       i_tx2_busy,
    output logic       o_busy,
    output logic       o_dropped
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HDR,
        ST_LEN,
        ST_STAT,
        ST_DATA,
        ST_CRC
    } state_t;

    localparam logic [23:0] TMO_LAST    = 24'(TIMEOUT - 1);
    localparam logic [7:0]  SYNC_BYTE   = 8'hD5;
    localparam logic [7:0]  STS_CRC_ERR = 8'h83;
    localparam logic [7:0]  STS_TIMEOUT = 8'h8C;

    // Receiver's CRC-8 (Dallas/Maxim iButton: reflected poly 0x8C, LSB first).
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] x;
        x = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 8'h8C) : (x >> 1);
        end
        return x;
    endfunction

    state_t      r_state;
    logic        r_wait;
    logic        r_port;
    logic [23:0] r_cnt;
    logic [7:0]  r_status;
    logic [7:0]  r_crc;
    logic [4:0]  r_len;
    logic [4:0]  r_idx;
    logic        r_cmd_start;
    logic        r_tx1_start;
    logic        r_tx2_start;
    logic [7:0]  r_tx1_data;
    logic [7:0]  r_tx2_data;
    logic        r_busy;
    logic        r_dropped;

    logic        w_tx_busy;
    logic        w_advance;
    logic        w_send;
    logic        w_send_port;
    logic [7:0]  w_send_byte;
    logic [7:0]  w_crc_next;
    logic [4:0]  w_len_clamped;
    logic        w_rx_any;

    // Byte to launch on the next edge. Start strobes are registered, so the
    // SEND phase is the cycle right after this decision.
    always_comb begin
        w_tx_busy     = r_port ? i_tx2_busy : i_tx1_busy;
        w_advance     = r_wait && !w_tx_busy;
        w_len_clamped = (i_exec_len > 5'd16) ? 5'd16 : i_exec_len;
        w_rx_any      = i_rx_packet_done || i_rx_packet_error;
        w_send        = 1'b0;
        w_send_port   = r_port;
        w_send_byte   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                // Error path launches the header straight away on the new port.
                if (i_rx_packet_error && !i_rx_packet_done) begin
                    w_send      = 1'b1;
                    w_send_port = i_rx_cmd_src;
                    w_send_byte = SYNC_BYTE;
                end
            end
            ST_EXEC: begin
                if (i_exec_done || (r_cnt == TMO_LAST)) begin
                    w_send      = 1'b1;
                    w_send_byte = SYNC_BYTE;
                end
            end
            ST_HDR: begin
                if (w_advance) begin
                    w_send      = 1'b1;
                    w_send_byte = {3'b000, r_len} + 8'd1;
                end
            end
            ST_LEN: begin
                if (w_advance) begin
                    w_send      = 1'b1;
                    w_send_byte = r_status;
                end
            end
            ST_STAT: begin
                if (w_advance) begin
                    w_send      = 1'b1;
                    w_send_byte = (r_len == 5'd0) ? r_crc : i_reply_data;
                end
            end
            ST_DATA: begin
                if (w_advance) begin
                    w_send      = 1'b1;
                    w_send_byte = (r_idx == r_len) ? r_crc : i_reply_data;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_crc_next = crc8_upd(r_crc, w_send_byte);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_wait      <= 1'b0;
            r_port      <= 1'b0;
            r_cnt       <= 24'd0;
            r_status    <= 8'h00;
            r_crc       <= 8'h00;
            r_len       <= 5'd0;
            r_idx       <= 5'd0;
            r_cmd_start <= 1'b0;
            r_tx1_start <= 1'b0;
            r_tx2_start <= 1'b0;
            r_tx1_data  <= 8'h00;
            r_tx2_data  <= 8'h00;
            r_busy      <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_cmd_start <= 1'b0;
            r_dropped   <= (r_state != ST_IDLE) && w_rx_any;
            r_tx1_start <= w_send && !w_send_port;
            r_tx2_start <= w_send && w_send_port;
            if (w_send) begin
                // The idle port's data is kept at zero.
                r_tx1_data <= w_send_port ? 8'h00 : w_send_byte;
                r_tx2_data <= w_send_port ? w_send_byte : 8'h00;
                r_wait     <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_rx_packet_done) begin
                        r_port      <= i_rx_cmd_src;
                        r_cmd_start <= 1'b1;
                        r_cnt       <= 24'd0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_EXEC;
                    end else if (i_rx_packet_error) begin
                        r_port   <= i_rx_cmd_src;
                        r_status <= STS_CRC_ERR;
                        r_len    <= 5'd0;
                        r_crc    <= 8'h00;
                        r_idx    <= 5'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_HDR;
                    end
                end
                ST_EXEC: begin
                    // exec_done has priority over a coincident expiry.
                    if (i_exec_done) begin
                        r_status <= i_exec_status;
                        r_len    <= w_len_clamped;
                        r_crc    <= 8'h00;
                        r_idx    <= 5'd0;
                        r_state  <= ST_HDR;
                    end else if (r_cnt == TMO_LAST) begin
                        r_status <= STS_TIMEOUT;
                        r_len    <= 5'd0;
                        r_crc    <= 8'h00;
                        r_idx    <= 5'd0;
                        r_state  <= ST_HDR;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                ST_HDR: begin
                    if (!r_wait) begin
                        r_wait <= 1'b1;
                    end else if (w_advance) begin
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (!r_wait) begin
                        r_wait <= 1'b1;
                    end else if (w_advance) begin
                        r_crc   <= w_crc_next;
                        r_state <= ST_STAT;
                    end
                end
                ST_STAT: begin
                    if (!r_wait) begin
                        r_wait <= 1'b1;
                    end else if (w_advance) begin
                        if (r_len == 5'd0) begin
                            r_state <= ST_CRC;
                        end else begin
                            r_crc   <= w_crc_next;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Index stays on the byte being sent through its SEND cycle.
                    if (!r_wait) begin
                        r_wait <= 1'b1;
                        r_idx  <= r_idx + 5'd1;
                    end else if (w_advance) begin
                        if (r_idx == r_len) begin
                            r_state <= ST_CRC;
                        end else begin
                            r_crc <= w_crc_next;
                        end
                    end
                end
                ST_CRC: begin
                    if (!r_wait) begin
                        r_wait <= 1'b1;
                    end else if (w_advance) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_start  = r_cmd_start;
    assign o_reply_addr = r_idx[3:0];
    assign o_tx1_data   = r_tx1_data;
    assign o_tx1_start  = r_tx1_start;
    assign o_tx2_data   = r_tx2_data;
    assign o_tx2_start  = r_tx2_start;
    assign o_busy       = r_busy;
    assign o_dropped    = r_dropped;

endmodule

// File: doc/s3g_reply_seq.md
# s3g_reply_seq

Reply sequencer for the S3G host link. It sits between the packet receiver, the command executor and the two byte-wide UART transmitters. For each received packet it starts the executor, or skips it on a CRC error, and waits for completion or timeout. It then frames the reply (0xD5, length, status, payload, CRC-8) and streams it byte-by-byte out of the port the command arrived on.

## Interface
- TIMEOUT, 1000000: cycles from cmd_start to forced timeout reply; counter is 24 bits, TIMEOUT ≤ 2^24−1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_packet_done  in  1  one-cycle pulse: valid packet received
- rx_packet_error  in  1  one-cycle pulse: packet CRC mismatch
- rx_cmd_src  in  1  source port of current packet (0 = port 1, 1 = port 2); valid on the done/error pulse
- cmd_start  out  1  one-cycle pulse to executor
- exec_done  in  1  one-cycle pulse: executor finished
- exec_status  in  8  status code, sampled on exec_done
- exec_len  in  5  reply payload byte count, sampled on exec_done; values >16 clamp to 16
- reply_addr  out  4  index into executor reply bytes
- reply_data  in  8  combinational read of reply byte at reply_addr
- tx1_data / tx2_data  out  8  byte to transmit
- tx1_start / tx2_start  out  1  one-cycle send strobe
- tx1_busy / tx2_busy  in  1  UART busy
- busy  out  1  high from accepted packet until last byte handed off
- dropped  out  1  one-cycle pulse: packet event ignored because busy

## Operation
- States: IDLE, EXEC, HDR, LEN, STAT, DATA, CRC. Each non-IDLE send state has SEND and WAIT phases.
- IDLE, rx_packet_done: latch port = rx_cmd_src, pulse cmd_start next cycle, go EXEC, clear timeout counter. If done and error arrive together, done wins.
- IDLE, rx_packet_error: latch port, set status = 0x83, len = 0, go HDR; no cmd_start.
- EXEC: on exec_done, latch status and min(exec_len, 16), go HDR. When the counter reaches TIMEOUT, use status 0x8C, len = 0, go HDR. exec_done in the same cycle as expiry wins.
- Byte order: 0xD5, (1 + len), status, reply[0..len−1], crc.
- crc: receiver's CRC-8 update function (same polynomial/bit equations), init 0x00, over status and payload bytes only.
- SEND phase: drive txN_data and pulse txN_start on the latched port only. The other port's start stays 0 and its data holds 0.
- WAIT phase: ignore txN_busy for exactly one cycle after the start, then wait until txN_busy = 0 before the next SEND.
- DATA: reply_addr = byte index. reply_data is sampled in the SEND cycle. Index increments per byte. len = 0 skips DATA.
- After the CRC byte's WAIT completes, return to IDLE and deassert busy.
- rx_packet_done or rx_packet_error while not IDLE: pulse dropped next cycle; state unaffected.
- rst at any point: return to IDLE at the next edge, abandoning any reply mid-packet.
- Reset values:
  - all outputs 0; busy 0, dropped 0
  - reply_addr 0, tx data 0
  - latched port 0, crc 0

## Timing
- Packet pulse in cycle T: busy and state change at T+1; cmd_start high in cycle T+1 only.
- exec_done at cycle E: first tx start (0xD5) at E+1.
- Error path: first tx start at T+1.
- Minimum spacing between consecutive starts: 2 cycles if busy never asserts, else busy-low + 1.
- Total bytes per reply = 4 + len.
- busy falls on the cycle after the final WAIT sees txN_busy = 0.
- Earliest next accepted packet: the following cycle.
- dropped: one cycle after the ignored pulse.

## Test plan
- Valid packet on port 1; exec_done status 0x00, len 0; UART busy 10 cycles per byte → port 1 sends D5, 01, 00, 00; tx2_start never asserts.
- Valid packet on port 2; status 0x81, len 3, reply bytes 0x00, 0x00, 0x00 → port 2 sends D5, 04, 81, 00, 00, 00, crc. crc must equal the receiver's CRC-8 over those four bytes: loop the output back into a receiver instance and check rx_packet_done.
- rx_packet_error on port 1 → no cmd_start; port 1 sends D5, 01, 83, crc(0x83). Loopback receiver reports packet_done.
- TIMEOUT = 50, executor silent → cmd_start, then at cycle 50 reply D5, 01, 8C, crc. A late exec_done is ignored.
- exec_len = 20 → exactly 16 payload bytes sent, reply_addr 0..15, length byte 0x11.
- Second rx_packet_done during a transmission → dropped pulse, reply completes unchanged. rst mid-DATA → busy 0 and no further starts.
